gci_std_display_vram_reader: RTL and testbench

//  Framebuffer read engine: the reading counterpart of the display clear/write path. On a start

---
 rtl/gci_std_display_vram_reader_if.sv | 30 +++
 rtl/gci_std_display_vram_reader.sv | 133 +++++++++++++
 tb/tb_gci_std_display_vram_reader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gci_std_display_vram_reader_if.sv
// Bundle of the VRAM read-request/response port and the pixel stream port of the
// framebuffer read engine.
//   master : the read engine (issues requests, sources pixels)
//   slave  : the environment (VRAM arbiter + scan-out/timing block)
// Signals:
//   oMEM_REQ_VALID / iMEM_REQ_BUSY / oMEM_ADDR   read request, valid/busy handshake
//   iMEM_RD_VALID / iMEM_RD_DATA                 in-order read responses {R,G,B}
//   oPIX_VALID / iPIX_BUSY / oPIX_DATA           pixel stream, valid/busy handshake
interface gci_std_display_vram_reader_if #(
  parameter int unsigned P_MEM_ADDR_N = 23
) ();
  logic                    oMEM_REQ_VALID;
  logic                    iMEM_REQ_BUSY;
  logic [P_MEM_ADDR_N-1:0] oMEM_ADDR;
  logic                    iMEM_RD_VALID;
  logic [23:0]             iMEM_RD_DATA;
  logic                    oPIX_VALID;
  logic                    iPIX_BUSY;
  logic [23:0]             oPIX_DATA;

  modport master (
    output oMEM_REQ_VALID, oMEM_ADDR, oPIX_VALID, oPIX_DATA,
    input  iMEM_REQ_BUSY, iMEM_RD_VALID, iMEM_RD_DATA, iPIX_BUSY
  );

  modport slave (
    input  oMEM_REQ_VALID, oMEM_ADDR, oPIX_VALID, oPIX_DATA,
    output iMEM_REQ_BUSY, iMEM_RD_VALID, iMEM_RD_DATA, iPIX_BUSY
  );
endinterface

// File: rtl/gci_std_display_vram_reader.sv
// Framebuffer read engine. On iSTART it walks pixel addresses 0..H*V-1 on the VRAM read
// request port, collects the in-order read responses in a show-ahead FIFO and streams them
// to the scan-out side.
// Ports:
//   iCLOCK       clock
//   inRESET      asynchronous reset, active low
//   iRESET_SYNC  synchronous reset / frame abort, active high
//   iSTART       frame request, only honoured when idle
//   oBUSY        high whenever a frame is in progress (state != idle)
//   oFINISH      one-cycle pulse after the last pixel was taken by the consumer
//   bus          request/response and pixel ports (master side)
module gci_std_display_vram_reader #(
  parameter int unsigned P_AREA_H       = 640,
  parameter int unsigned P_AREA_V       = 480,
  parameter int unsigned P_AREAA_HV_N   = 19,
  parameter int unsigned P_MEM_ADDR_N   = 23,
  parameter int unsigned P_FIFO_DEPTH_N = 4
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iRESET_SYNC,
  input  logic iSTART,
  output logic oBUSY,
  output logic oFINISH,
  gci_std_display_vram_reader_if.master bus
);

  localparam int unsigned Depth    = 1 << P_FIFO_DEPTH_N;
  localparam int unsigned AreaLast = P_AREA_H * P_AREA_V - 1;

  typedef logic [P_FIFO_DEPTH_N:0]   cnt_t;
  typedef logic [P_FIFO_DEPTH_N+1:0] sum_t;
  typedef logic [P_FIFO_DEPTH_N-1:0] ptr_t;
  typedef logic [P_AREAA_HV_N-1:0]   addr_t;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StEnd} state_e;

  state_e      state_q;
  addr_t       addr_q;
  cnt_t        out_q, out_d;   // requests accepted but not yet answered
  cnt_t        cnt_q, cnt_d;   // FIFO occupancy
  ptr_t        wr_ptr_q, rd_ptr_q;
  logic [23:0] fifo_q [Depth];

  logic req_valid, accept, push, pop, last_addr, fifo_nempty;

  // Credit: every accepted request owns a FIFO slot until it is popped, so the FIFO can
  // never overflow regardless of response timing.
  assign req_valid   = (state_q == StRead) &&
                       ((sum_t'(out_q) + sum_t'(cnt_q)) < sum_t'(Depth));
  assign accept      = req_valid && !bus.iMEM_REQ_BUSY;
  // Responses with nothing outstanding are leftovers from an aborted frame.
  assign push        = bus.iMEM_RD_VALID && (out_q != '0);
  assign fifo_nempty = (cnt_q != '0);
  assign pop         = fifo_nempty && !bus.iPIX_BUSY;
  assign last_addr   = (addr_q == addr_t'(AreaLast));

  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    case ({accept, push})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: ;
    endcase
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (iRESET_SYNC) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case (state_q)
        StIdle: begin
          if (iSTART) state_q <= StRead;
        end
        StRead: begin
          // The counter stops on the last address so it never wraps inside a frame.
          if (accept) begin
            if (last_addr) state_q <= StDrain;
            else           addr_q  <= addr_q + 1'b1;
          end
        end
        StDrain: begin
          // Look at next-state counts so oFINISH follows the last pop by one cycle.
          if ((out_d == '0) && (cnt_d == '0)) state_q <= StEnd;
        end
        StEnd: begin
          state_q <= StIdle;
          addr_q  <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO storage needs no reset: reads are masked while empty.
  always_ff @(posedge iCLOCK) begin
    if (push) fifo_q[wr_ptr_q] <= bus.iMEM_RD_DATA;
  end

  assign bus.oMEM_REQ_VALID = req_valid;
  assign bus.oMEM_ADDR      = P_MEM_ADDR_N'(addr_q);
  assign bus.oPIX_VALID     = fifo_nempty;
  assign bus.oPIX_DATA      = fifo_nempty ? fifo_q[rd_ptr_q] : 24'h000000;
  assign oBUSY              = (state_q != StIdle);
  assign oFINISH            = (state_q == StEnd);

  // The credit rule must make a push into a full FIFO impossible.
  assert property (@(posedge iCLOCK) disable iff (!inRESET)
                   !(push && (cnt_q == cnt_t'(Depth))));

endmodule

// File: tb/tb_gci_std_display_vram_reader.sv
// Self-checking bench for gci_std_display_vram_reader: a small 4x2 frame with a 4-entry
// FIFO, a latency-configurable in-order memory model and a transaction-count reference
// model (requests issued, responses kept, pixels taken) that predicts every output.
module tb_gci_std_display_vram_reader;
  localparam int unsigned H     = 4;
  localparam int unsigned V     = 2;
  localparam int          HV    = H * V;
  localparam int unsigned HVN   = 4;
  localparam int unsigned MAN   = 8;
  localparam int unsigned DN    = 2;
  localparam int          Depth = 1 << DN;

  logic clk = 1'b0;
  logic rst_n, rst_sync, start;
  logic busy, finish;

  gci_std_display_vram_reader_if #(.P_MEM_ADDR_N(MAN)) bus ();

  gci_std_display_vram_reader #(
    .P_AREA_H      (H),
    .P_AREA_V      (V),
    .P_AREAA_HV_N  (HVN),
    .P_MEM_ADDR_N  (MAN),
    .P_FIFO_DEPTH_N(DN)
  ) dut (
    .iCLOCK     (clk),
    .inRESET    (rst_n),
    .iRESET_SYNC(rst_sync),
    .iSTART     (start),
    .oBUSY      (busy),
    .oFINISH    (finish),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame progress in transaction counts.
  bit active, finishing;
  int n_acc, n_resp, n_pop, fifo_n, n_finish, cyc, last_due;

  typedef struct {int addr; int due;} rsp_t;
  rsp_t mem_q[$];

  // Stimulus knobs.
  int req_busy_mode, pix_busy_mode, lat_min, lat_max;
  bit start_req, sync_req;

  task automatic cycle();
    bit exp_rv, acc, pop, rv;
    int addr, lat, due;
    rsp_t r;
    @(negedge clk);
    exp_rv = active && (n_acc < HV) && ((n_acc - n_pop) < Depth);
    check("busy", busy, active);
    check("finish", finish, finishing);
    check("req_valid", bus.oMEM_REQ_VALID, exp_rv);
    if (exp_rv)  check("req_addr", bus.oMEM_ADDR, n_acc);
    if (!active) check("idle_addr", bus.oMEM_ADDR, 0);
    check("pix_valid", bus.oPIX_VALID, fifo_n > 0);
    if (fifo_n == 0) check("pix_data_empty", bus.oPIX_DATA, 0);

    case (req_busy_mode)
      1:       bus.iMEM_REQ_BUSY = ~bus.iMEM_REQ_BUSY;
      2:       bus.iMEM_REQ_BUSY = 1'($urandom_range(0, 1));
      default: bus.iMEM_REQ_BUSY = 1'b0;
    endcase
    case (pix_busy_mode)
      1:       bus.iPIX_BUSY = 1'b1;
      2:       bus.iPIX_BUSY = ($urandom_range(0, 3) == 0);
      default: bus.iPIX_BUSY = 1'b0;
    endcase
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    bus.iMEM_RD_VALID = rv;
    bus.iMEM_RD_DATA  = rv ? 24'(mem_q[0].addr * 'h010203) : 24'($urandom);
    start    = start_req;
    rst_sync = sync_req;

    acc  = bus.oMEM_REQ_VALID && !bus.iMEM_REQ_BUSY;
    addr = int'(bus.oMEM_ADDR);
    pop  = bus.oPIX_VALID && !bus.iPIX_BUSY;
    if (pop && rst_n && !rst_sync)
      check("pix_data", bus.oPIX_DATA, 32'((n_pop * 'h010203) & 'hFFFFFF));

    @(posedge clk);
    // The memory answers whatever the arbiter accepted, even across an abort.
    if (rv) void'(mem_q.pop_front());
    if (acc && rst_n) begin
      lat = int'($urandom_range(lat_min, lat_max));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.addr = addr;
      r.due  = due;
      mem_q.push_back(r);
    end
    if (!rst_n || rst_sync) begin
      active = 0; finishing = 0;
      n_acc = 0; n_resp = 0; n_pop = 0; fifo_n = 0;
    end else begin
      if (rv && (n_acc > n_resp)) begin n_resp++; fifo_n++; end
      if (acc) n_acc++;
      if (pop) begin n_pop++; fifo_n--; end
      if (finishing) begin
        active = 0; finishing = 0; n_finish++;
      end else if (active && (n_pop == HV)) begin
        finishing = 1;
      end else if (!active && start) begin
        active = 1; n_acc = 0; n_resp = 0; n_pop = 0; fifo_n = 0;
      end
    end
    cyc++;
  endtask

  task automatic start_frame();
    start_req = 1;
    cycle();
    start_req = 0;
  endtask

  task automatic wait_finish(input bit poke_start);
    int f0 = n_finish;
    int k = 0;
    while ((n_finish == f0) && (k < 3000)) begin
      start_req = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle();
      k++;
    end
    start_req = 0;
    check("frame_done", n_finish - f0, 1);
    check("frame_reqs", n_acc, HV);
    repeat (2) cycle();
  endtask

  initial begin
    int f0, k;
    rst_n = 0; rst_sync = 0; start = 0;
    bus.iMEM_REQ_BUSY = 0; bus.iMEM_RD_VALID = 0; bus.iMEM_RD_DATA = '0; bus.iPIX_BUSY = 0;
    active = 0; finishing = 0; n_acc = 0; n_resp = 0; n_pop = 0; fifo_n = 0;
    n_finish = 0; cyc = 0; last_due = -1;
    req_busy_mode = 0; pix_busy_mode = 0; lat_min = 2; lat_max = 2;
    start_req = 0; sync_req = 0;

    repeat (3) cycle();
    rst_n = 1;
    repeat (2) cycle();

    // Plain frame, 2-cycle memory latency, no stalls.
    start_frame();
    wait_finish(0);

    // Consumer stalled: credit limits requests to the FIFO depth.
    pix_busy_mode = 1;
    start_frame();
    repeat (30) cycle();
    check("credit_stall_reqs", n_acc, Depth);
    check("credit_stall_valid", bus.oMEM_REQ_VALID, 0);
    pix_busy_mode = 0;
    wait_finish(0);

    // Arbiter busy every other cycle.
    req_busy_mode = 1;
    start_frame();
    wait_finish(0);
    req_busy_mode = 0;

    // Abort mid-frame with reads in flight.
    f0 = n_finish;
    start_frame();
    k = 0;
    while (!((n_pop >= 3) && (mem_q.size() >= 2)) && (k < 200)) begin cycle(); k++; end
    check("abort_setup_pop", n_pop, 3);
    check("abort_setup_inflight", mem_q.size(), 2);
    sync_req = 1;
    cycle();
    sync_req = 0;
    k = 0;
    while ((mem_q.size() > 0) && (k < 50)) begin cycle(); k++; end
    repeat (3) cycle();
    check("abort_no_finish", n_finish - f0, 0);
    start_frame();
    wait_finish(0);

    // iSTART toggling while a frame runs.
    start_frame();
    wait_finish(1);

    // Randomised stalls and latencies.
    req_busy_mode = 2; pix_busy_mode = 2; lat_min = 1; lat_max = 4;
    repeat (4) begin
      start_frame();
      wait_finish(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
